// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the mux scan sequencer: state encodings and sizing helpers.
package mux_scan_sequencer_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   function automatic int unsigned nch_of(input int unsigned sel_w);
      return 1 << sel_w;
   endfunction

   // Settle counter must hold SETTLE_CYCLES; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned settle);
      return (settle < 2) ? 1 : $clog2(settle + 1);
   endfunction

endpackage

// File: rtl/mux_scan_sequencer_settle_timer.sv
// Per-channel settle down-counter: loadable, decrements to zero and holds there.
module mux_scan_sequencer_settle_timer #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] value,
   output logic             zero
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= value;
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - WIDTH'(1);
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// One-shot sweep of a 1-bit channel mux: steps sel, waits settle time per channel,
// captures mux_in into result and signals completion with a done pulse.
module mux_scan_sequencer
   import mux_scan_sequencer_pkg::*;
#(
   parameter int unsigned SEL_W         = 2,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    mux_in,
   output logic [SEL_W-1:0]        sel,
   output logic                    busy,
   output logic                    done,
   output logic [(1<<SEL_W)-1:0]   result
);

   localparam int unsigned NCH = nch_of(SEL_W);
   localparam int unsigned CNT_W = cnt_width(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE_CYCLES);
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NCH - 1);

   logic [1:0]       state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [NCH-1:0]   result_q, result_d;
   logic             timer_load, timer_en, timer_zero;

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      result_d   = result_q;
      timer_load = 1'b0;
      timer_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_SETTLE;
               sel_d      = '0;
               result_d   = '0;
               busy_d     = 1'b1;
               timer_load = 1'b1;
            end
         end
         ST_SETTLE: begin
            timer_en = 1'b1;
            // Capture only when the settle count has expired; earlier glitches are ignored.
            if (timer_zero) begin
               result_d[sel_q] = mux_in;
               if (sel_q == LAST_SEL) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  sel_d      = sel_q + SEL_W'(1);
                  timer_load = 1'b1;
               end
            end
         end
         ST_DONE: begin
            sel_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sel_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   mux_scan_sequencer_settle_timer #(
      .WIDTH (CNT_W)
   ) u_settle_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (timer_load),
      .en    (timer_en),
      .value (SETTLE_VAL),
      .zero  (timer_zero)
   );

   assign sel    = sel_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule
